mem_request_unit: RTL

- Memory-stage requester on the CPU side of the dcache access logic; the initiator that drives dmemREN/dmemWEN/dmemaddr/dmemstore/datomic/halt and consumes dhit/dmemload/flushed.
- Accepts one load/store/LL/SC/halt op from the pipeline, holds the request until dhit, stalls the pipeline meanwhile, and runs the halt-and-flush sequence.
- Maintains saturating load/store/wait counters for performance analysis.

---
 rtl/mem_request_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_request_unit.sv
// Memory-stage requester: holds one load/store/LL/SC until dhit, stalls the pipeline
// meanwhile, sequences halt-and-flush, and keeps saturating load/store/wait counters.
module mem_request_unit #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             op_valid,
    input  logic             op_ren,
    input  logic             op_wen,
    input  logic             op_atomic,
    input  logic             op_halt,
    input  logic [31:0]      op_addr,
    input  logic [31:0]      op_wdata,
    input  logic             dhit,
    input  logic [31:0]      dmemload,
    input  logic             flushed,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             datomic,
    output logic [31:0]      dmemaddr,
    output logic [31:0]      dmemstore,
    output logic             halt,
    output logic             stall,
    output logic [31:0]      rdata,
    output logic             rdata_valid,
    output logic             op_err,
    output logic             done,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, HALT_WAIT, HALTED} state_e;

    state_e            state_q, state_d;
    logic              rd_q, rd_d, wr_q, wr_d, atomic_q, atomic_d;
    logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [CNT_W-1:0]  load_cnt_q, load_cnt_d, store_cnt_q, store_cnt_d, wait_cnt_q, wait_cnt_d;

    logic in_req, op_legal, op_bad, read_hit, stall_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // op_halt outranks the direction bits, so halt ops are never flagged as errors.
    assign op_legal = op_valid && !op_halt && (op_ren ^ op_wen) && (op_addr[1:0] == 2'b00);
    assign op_bad   = op_valid && !op_halt && ((op_ren && op_wen) || (op_addr[1:0] != 2'b00));
    assign in_req   = (state_q == REQ);
    assign read_hit = in_req && rd_q && dhit;

    always_comb begin
        // NOTE: every _d gets a default before the case, so no path can infer a latch.
        state_d     = state_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        atomic_d    = atomic_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = read_hit ? dmemload : rdata_q;
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        stall_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_valid && op_halt) begin
                    state_d = HALT_WAIT;
                    stall_c = 1'b1;
                end else if (op_legal) begin
                    state_d  = REQ;
                    rd_d     = op_ren;
                    wr_d     = op_wen;
                    atomic_d = op_atomic;
                    addr_d   = {op_addr[31:2], 2'b00};
                    wdata_d  = op_wdata;
                    stall_c  = 1'b1;
                end
            end
            REQ: begin
                if (dhit) begin
                    state_d = IDLE;
                    if (rd_q) load_cnt_d = sat_inc(load_cnt_q);
                    if (wr_q) store_cnt_d = sat_inc(store_cnt_q);
                end else begin
                    stall_c    = 1'b1;
                    wait_cnt_d = sat_inc(wait_cnt_q);
                end
            end
            HALT_WAIT: begin
                stall_c = 1'b1;
                if (flushed) state_d = HALTED;
            end
            default: stall_c = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: the held request and rdata are reset too, since every output must read 0 after RST.
        if (RST) begin
            state_q     <= IDLE;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            atomic_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            atomic_q    <= atomic_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // Outputs are forced low while RST is asserted so that no state leaks out during reset.
    assign dmemREN     = !RST && in_req && rd_q;
    assign dmemWEN     = !RST && in_req && wr_q;
    assign datomic     = !RST && in_req && atomic_q;
    assign dmemaddr    = (!RST && in_req) ? addr_q : 32'h0;
    assign dmemstore   = (!RST && in_req && wr_q) ? wdata_q : 32'h0;
    assign rdata_valid = !RST && read_hit;
    assign rdata       = RST ? 32'h0 : rdata_d;
    assign stall       = !RST && stall_c;
    assign op_err      = !RST && (state_q == IDLE) && op_bad;
    assign halt        = !RST && ((state_q == HALT_WAIT) || (state_q == HALTED));
    assign done        = !RST && (state_q == HALTED);
    assign load_cnt    = load_cnt_q;
    assign store_cnt   = store_cnt_q;
    assign wait_cnt    = wait_cnt_q;

endmodule
